inv_sub_bytes_seq: RTL

- Iterative inverse SubBytes unit for the AES decryption datapath.
- Accepts one block of `size` bytes through a valid/ready handshake.
- Applies the AES inverse S-box to `bytes_per_cycle` bytes per clock.
- Presents the result through a valid/yumi handshake.
- Companion to the combinational forward sub_bytes; trades latency for area by reusing a small number of inverse S-box instances.

---
 rtl/inv_sub_bytes_seq_pkg.sv | 56 +++++
 rtl/inv_sub_bytes_seq_if.sv | 21 ++
 rtl/inv_sub_bytes_seq_inv_sbox.sv | 9 +
 rtl/inv_sub_bytes_seq.sv | 110 +++++++++++
 4 files changed

// File: rtl/inv_sub_bytes_seq_pkg.sv
// Shared AES byte type, S-box tables and FSM state encoding for the
// iterative inverse SubBytes unit.
package inv_sub_bytes_seq_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Forward table, kept alongside the inverse so sub_bytes shares one source.
    localparam byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic byte_t sbox_byte(input byte_t b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/inv_sub_bytes_seq_if.sv
// Block handshake bundle: valid/ready on the input side, valid/yumi on the output side.
interface inv_sub_bytes_seq_if #(
    parameter int size = 16
);
    logic                v_i;
    logic                ready_o;
    logic [size*8-1:0]   block_i;
    logic                v_o;
    logic                yumi_i;
    logic [size*8-1:0]   block_o;

    modport master (
        output v_i, block_i, yumi_i,
        input  ready_o, v_o, block_o
    );

    modport slave (
        input  v_i, block_i, yumi_i,
        output ready_o, v_o, block_o
    );
endinterface

// File: rtl/inv_sub_bytes_seq_inv_sbox.sv
// Single-byte AES inverse S-box lookup, purely combinational.
module inv_sbox
    import inv_sub_bytes_seq_pkg::*;
(
    input  byte_t din,
    output byte_t dout
);
    assign dout = INV_SBOX[din];
endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Iterative inverse SubBytes: one block is latched, then bytes_per_cycle bytes
// per clock are replaced in place by their inverse S-box value.
module inv_sub_bytes_seq
    import inv_sub_bytes_seq_pkg::*;
#(
    parameter int size            = 16,
    parameter int bytes_per_cycle = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    inv_sub_bytes_seq_if.slave bus
);
    localparam int N  = size / bytes_per_cycle;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(N - 1);

    if (size % bytes_per_cycle != 0) begin : g_bad_cfg
        $error("inv_sub_bytes_seq: size must be a multiple of bytes_per_cycle");
    end

    state_e            state_r;
    state_e            state_next_s;
    logic [CW-1:0]     cnt_r;
    logic [CW-1:0]     cnt_next_s;
    logic [size*8-1:0] data_r;
    logic [size*8-1:0] data_next_s;
    logic              ready_r;
    logic              v_r;
    int                chunk_base_s;
    byte_t             sbox_in_s  [bytes_per_cycle];
    byte_t             sbox_out_s [bytes_per_cycle];

    // Select the chunk addressed by the counter; byte 0 sits at the MSB end.
    always_comb begin
        chunk_base_s = int'(cnt_r) * bytes_per_cycle;
        for (int j = 0; j < bytes_per_cycle; j++) begin
            sbox_in_s[j] = data_r[(size - 1 - chunk_base_s - j) * 8 +: 8];
        end
    end

    for (genvar g = 0; g < bytes_per_cycle; g++) begin : g_sbox
        inv_sbox u_inv_sbox (
            .din  (sbox_in_s[g]),
            .dout (sbox_out_s[g])
        );
    end

    // Next-state, counter and in-place chunk write-back.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        data_next_s  = data_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.v_i && ready_r) begin
                    state_next_s = ST_BUSY;
                    cnt_next_s   = {CW{1'b0}};
                    data_next_s  = bus.block_i;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                for (int j = 0; j < bytes_per_cycle; j++) begin
                    data_next_s[(size - 1 - chunk_base_s - j) * 8 +: 8] = sbox_out_s[j];
                end
                if (cnt_r == LAST_CHUNK) begin
                    state_next_s = ST_DONE;
                    cnt_next_s   = {CW{1'b0}};
                end else begin
                    cnt_next_s   = cnt_r + CW'(1'b1);
                end
            end
            ST_DONE: begin
                // A yumi edge only returns to IDLE; acceptance waits a cycle.
                if (bus.yumi_i) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = {CW{1'b0}};
            end
        endcase
    end

    // State, datapath and registered handshake flags.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
            data_r  <= {(size*8){1'b0}};
            ready_r <= 1'b1;
            v_r     <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            data_r  <= data_next_s;
            ready_r <= (state_next_s == ST_IDLE);
            v_r     <= (state_next_s == ST_DONE);
        end
    end

    assign bus.ready_o = ready_r;
    assign bus.v_o     = v_r;
    assign bus.block_o = data_r;

endmodule
